// File: rtl/rigel_bram_pkg.sv
// Shared defaults and pointer/count types for the block-RAM FIFO controller.
package rigel_bram_pkg;
  localparam int ADDR_BITS_DEF = 9;
  localparam int DATA_BITS_DEF = 32;

  typedef logic [ADDR_BITS_DEF:0]   ptr_t;
  typedef logic [ADDR_BITS_DEF+1:0] cnt_t;
endpackage

// File: rtl/bram_fifo_skid.sv
// Two-entry head/skid output buffer fed by the 1-cycle-latency RAM read port.
module bram_fifo_skid #(
  parameter int DATA_BITS = 32
) (
  input  logic                 CLK,
  input  logic                 reset,
  input  logic                 land_valid,
  input  logic [DATA_BITS-1:0] land_data,
  input  logic                 pop,
  output logic [1:0]           occ,
  output logic                 out_valid,
  output logic [DATA_BITS-1:0] out_data
);
  logic                 head_v_q, head_v_d, skid_v_q, skid_v_d;
  logic [DATA_BITS-1:0] head_q, head_d, skid_q, skid_d;

  always_comb begin
    head_v_d = head_v_q;
    head_d   = head_q;
    skid_v_d = skid_v_q;
    skid_d   = skid_q;
    if (pop) begin
      if (skid_v_q) begin
        head_d   = skid_q;
        head_v_d = 1'b1;
        skid_v_d = land_valid;
        skid_d   = land_data;
      end else begin
        head_v_d = land_valid;
        if (land_valid) head_d = land_data;
      end
    end else if (land_valid) begin
      // Head keeps its word while stalled; a late landing parks in the skid.
      if (!head_v_q) begin
        head_d   = land_data;
        head_v_d = 1'b1;
      end else begin
        skid_d   = land_data;
        skid_v_d = 1'b1;
      end
    end
  end

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      head_v_q <= 1'b0;
      skid_v_q <= 1'b0;
      head_q   <= '0;
      skid_q   <= '0;
    end else begin
      head_v_q <= head_v_d;
      skid_v_q <= skid_v_d;
      head_q   <= head_d;
      skid_q   <= skid_d;
    end
  end

  assign occ       = {1'b0, head_v_q} + {1'b0, skid_v_q};
  assign out_valid = head_v_q;
  assign out_data  = head_q;
endmodule

// File: rtl/bram_fifo_ctrl.sv
// FIFO control around one dual-port block RAM plus a 2-entry output buffer.
// Optional high-water mark tracking is built when BRAM_FIFO_HWM_EN is defined.
module bram_fifo_ctrl
  import rigel_bram_pkg::*;
#(
  parameter int ADDR_BITS = ADDR_BITS_DEF,
  parameter int DATA_BITS = DATA_BITS_DEF
) (
  input  logic                 CLK,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [DATA_BITS-1:0] in_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [DATA_BITS-1:0] out_data,
  output logic [ADDR_BITS+1:0] count,
  output logic                 ram_ena,
  output logic                 ram_wea,
  output logic [ADDR_BITS-1:0] ram_addra,
  output logic [DATA_BITS-1:0] ram_dia,
  output logic                 ram_enb,
  output logic [ADDR_BITS-1:0] ram_addrb,
  input  logic [DATA_BITS-1:0] ram_dob
`ifdef BRAM_FIFO_HWM_EN
  ,
  output logic [ADDR_BITS+1:0] hwm,
  input  logic                 hwm_clr
`endif
);
  logic [ADDR_BITS:0] wr_q, wr_d, rd_q, rd_d, ram_cnt;
  logic               infl_q;
  logic               push, pop;
  logic [1:0]         occ;
  logic [2:0]         pend;

  assign ram_cnt = wr_q - rd_q;
  // ram_cnt never exceeds DEPTH, so its MSB alone flags full.
  assign in_ready = !ram_cnt[ADDR_BITS];
  assign push     = in_valid && in_ready;
  assign pop      = out_valid && out_ready;

  // Words owed to the buffer after this cycle's pop; issue only if one slot is free.
  assign pend    = {1'b0, occ} + {2'b0, infl_q} - {2'b0, pop};
  assign ram_enb = (ram_cnt != '0) && (pend < 3'd2);

  assign ram_ena   = push;
  assign ram_wea   = push;
  assign ram_addra = wr_q[ADDR_BITS-1:0];
  assign ram_dia   = in_data;
  assign ram_addrb = rd_q[ADDR_BITS-1:0];

  assign wr_d = wr_q + {{ADDR_BITS{1'b0}}, push};
  assign rd_d = rd_q + {{ADDR_BITS{1'b0}}, ram_enb};

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      wr_q   <= '0;
      rd_q   <= '0;
      infl_q <= 1'b0;
    end else begin
      wr_q   <= wr_d;
      rd_q   <= rd_d;
      infl_q <= ram_enb;
    end
  end

  bram_fifo_skid #(.DATA_BITS(DATA_BITS)) u_skid (
    .CLK       (CLK),
    .reset     (reset),
    .land_valid(infl_q),
    .land_data (ram_dob),
    .pop       (pop),
    .occ       (occ),
    .out_valid (out_valid),
    .out_data  (out_data)
  );

  assign count = {1'b0, ram_cnt} + {{(ADDR_BITS+1){1'b0}}, infl_q} + {{ADDR_BITS{1'b0}}, occ};

`ifdef BRAM_FIFO_HWM_EN
  logic [ADDR_BITS+1:0] count_d, hwm_q, hwm_d;

  assign count_d = count + {{(ADDR_BITS+1){1'b0}}, push} - {{(ADDR_BITS+1){1'b0}}, pop};

  always_comb begin
    hwm_d = hwm_q;
    if (hwm_clr)              hwm_d = count_d;
    else if (count_d > hwm_q) hwm_d = count_d;
  end

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) hwm_q <= '0;
    else       hwm_q <= hwm_d;
  end

  assign hwm = hwm_q;
`endif
endmodule

// File: tb/tb_bram_fifo_ctrl.sv
// Bench for bram_fifo_ctrl: behavioural RAM, queue reference model, directed + random traffic.
module tb_bram_fifo_ctrl;
  localparam int AB = 9;
  localparam int DB = 32;

  logic          CLK = 1'b0;
  logic          reset;
  logic          in_valid, in_ready, out_valid, out_ready;
  logic [DB-1:0] in_data, out_data;
  logic [AB+1:0] count;
  logic          ram_ena, ram_wea, ram_enb;
  logic [AB-1:0] ram_addra, ram_addrb;
  logic [DB-1:0] ram_dia, ram_dob;
`ifdef BRAM_FIFO_HWM_EN
  logic [AB+1:0] hwm;
  logic          hwm_clr;
`endif

  bram_fifo_ctrl #(.ADDR_BITS(AB), .DATA_BITS(DB)) dut (
    .CLK(CLK), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .count(count),
    .ram_ena(ram_ena), .ram_wea(ram_wea), .ram_addra(ram_addra), .ram_dia(ram_dia),
    .ram_enb(ram_enb), .ram_addrb(ram_addrb), .ram_dob(ram_dob)
`ifdef BRAM_FIFO_HWM_EN
    , .hwm(hwm), .hwm_clr(hwm_clr)
`endif
  );

  always #5 CLK = ~CLK;

  // 512x32 RAM, 1-cycle read latency on port B.
  logic [DB-1:0] mem [0:(1<<AB)-1];
  always @(posedge CLK) begin
    if (ram_ena && ram_wea) mem[ram_addra] <= ram_dia;
    if (ram_enb) ram_dob <= mem[ram_addrb];
  end

  logic [DB-1:0] q[$];
  int            nvec = 0, nerr = 0, npop = 0;
  logic          s_ir, s_ov, s_enb, s_wea;
  logic [DB-1:0] s_od, stall_d;
  logic [AB+1:0] s_cnt;
  bit            stalled = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // One clock: drive, sample at negedge against the model, advance model at posedge.
  task automatic cyc(input logic iv, input logic [DB-1:0] d, input logic ordy);
    bit acc_push, acc_pop;
    in_valid = iv; in_data = d; out_ready = ordy;
    @(negedge CLK);
    s_ir = in_ready; s_ov = out_valid; s_od = out_data; s_enb = ram_enb;
    s_wea = ram_wea; s_cnt = count;
    chk("count", 64'(count), 64'(q.size()));
    if (q.size() == 0) chk("ov_empty", 64'(out_valid), 64'd0);
    else if (out_valid) chk("head", 64'(out_data), 64'(q[0]));
    if (stalled) begin
      chk("stall_ov", 64'(out_valid), 64'd1);
      chk("stall_od", 64'(out_data), 64'(stall_d));
    end
    stalled  = out_valid && !out_ready;
    stall_d  = out_data;
    acc_push = in_valid && in_ready;
    acc_pop  = out_valid && out_ready;
    @(posedge CLK);
    if (acc_pop && q.size() > 0) begin
      void'(q.pop_front());
      npop++;
    end
    if (acc_push) q.push_back(d);
    #1;
  endtask

  task automatic drain();
    int b = 0;
    while (q.size() > 0 && b < 3000) begin
      cyc(1'b0, '0, 1'b1);
      b++;
    end
    chk("drain_left", 64'(q.size()), 64'd0);
    chk("drain_cnt", 64'(count), 64'd0);
  endtask

  task automatic reset_checks(input string tag);
    chk({tag, "_ov"}, 64'(out_valid), 64'd0);
    chk({tag, "_od"}, 64'(out_data), 64'd0);
    chk({tag, "_cnt"}, 64'(count), 64'd0);
    chk({tag, "_ir"}, 64'(in_ready), 64'd1);
    chk({tag, "_enb"}, 64'(ram_enb), 64'd0);
  endtask

  initial begin
    int acc, b;
    logic [DB-1:0] w;
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
`ifdef BRAM_FIFO_HWM_EN
    hwm_clr = 1'b0;
`endif
    #3;
    reset_checks("rst");
`ifdef BRAM_FIFO_HWM_EN
    chk("rst_hwm", 64'(hwm), 64'd0);
`endif
    @(posedge CLK); #1 reset = 1'b0;

    // Single-word latency.
    cyc(1'b1, 32'hA5A5_0001, 1'b1);
    chk("lat_wea", 64'(s_wea), 64'd1);
    cyc(1'b0, '0, 1'b1);
    chk("lat_enb_t1", 64'(s_enb), 64'd1);
    cyc(1'b0, '0, 1'b1);
    chk("lat_ov_t2", 64'(s_ov), 64'd0);
    cyc(1'b0, '0, 1'b1);
    chk("lat_ov_t3", 64'(s_ov), 64'd1);
    chk("lat_od_t3", 64'(s_od), 64'hA5A5_0001);
    cyc(1'b0, '0, 1'b1);
    chk("lat_cnt_t4", 64'(s_cnt), 64'd0);

    // Fill to DEPTH+2 with the consumer stalled.
    acc = 0; b = 0;
    while (acc < 514 && b < 700) begin
      w = $urandom;
      cyc(1'b1, w, 1'b0);
      if (s_ir) acc++;
      b++;
    end
    chk("fill_acc", 64'(acc), 64'd514);
    cyc(1'b1, 32'hDEAD_BEEF, 1'b0);
    chk("full_ir", 64'(s_ir), 64'd0);
    chk("full_cnt", 64'(s_cnt), 64'd514);
    cyc(1'b0, '0, 1'b1);
    chk("pop1_ir", 64'(s_ir), 64'd0);
    chk("pop1_enb", 64'(s_enb), 64'd1);
    cyc(1'b0, '0, 1'b1);
    chk("pop2_ir", 64'(s_ir), 64'd1);
    drain();

    // Sustained streaming across pointer wrap.
    npop = 0;
    repeat (2000) begin
      w = $urandom;
      cyc(1'b1, w, 1'b1);
    end
    chk("stream_pops", 64'(npop), 64'd1997);
    drain();

    // Random push/stall traffic.
    repeat (1500) begin
      w = $urandom;
      cyc(1'($urandom_range(0, 1)), w, 1'($urandom_range(0, 3) != 0));
    end
    drain();

    // Reset with the buffer full and words still in RAM.
    repeat (4) begin
      w = $urandom;
      cyc(1'b1, w, 1'b0);
    end
    cyc(1'b0, '0, 1'b0);
    cyc(1'b0, '0, 1'b0);
    chk("pre_rst_cnt", 64'(count), 64'd4);
    reset = 1'b1;
    #1;
    reset_checks("mid_rst");
    q.delete();
    stalled = 0;
    @(posedge CLK); #1 reset = 1'b0;
    cyc(1'b1, 32'h1234_5678, 1'b1);
    cyc(1'b0, '0, 1'b1);
    chk("post_enb", 64'(s_enb), 64'd1);
    cyc(1'b0, '0, 1'b1);
    chk("post_ov_t2", 64'(s_ov), 64'd0);
    cyc(1'b0, '0, 1'b1);
    chk("post_od_t3", 64'(s_od), 64'h1234_5678);
    drain();

`ifdef BRAM_FIFO_HWM_EN
    hwm_clr = 1'b1;
    cyc(1'b0, '0, 1'b0);
    hwm_clr = 1'b0;
    repeat (300) begin
      w = $urandom;
      cyc(1'b1, w, 1'b0);
    end
    cyc(1'b0, '0, 1'b0);
    drain();
    chk("hwm_300", 64'(hwm), 64'd300);
    hwm_clr = 1'b1;
    cyc(1'b0, '0, 1'b0);
    hwm_clr = 1'b0;
    chk("hwm_clr", 64'(hwm), 64'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
